encrypt_multi: RTL and testbench

- Iterative, parametrised DES engine: one datapath is reused across cycles, and it executes UNROLL rounds per clock.
- Supports encryption and decryption, selected per operation by a mode input.
- It is the multi-cycle successor to the fully unrolled combinational encryptor. It is built from the same cells: pre/post-processing permutations, round and key_schedule.
- A four-phase req/ack handshake connects it to the host controller.

---
 rtl/encrypt_multi.sv | 200 ++++++++++++++++++++
 tb/tb_encrypt_multi.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/encrypt_multi.sv
// Iterative DES encrypt/decrypt engine, UNROLL rounds per clock; ENCRYPT_MULTI_ZEROISE_EN clears secrets after each op.
// Latency: ack rises N_R/UNROLL + 2 edges after req is sampled high.
// Four-phase req/ack: result and ack hold in DONE until req is seen low; new ops start only from IDLE.
`ifndef N_R
`define N_R 16
`endif
`ifndef N_K
`define N_K 64
`endif
`ifndef N_B
`define N_B 64
`endif

module encrypt_multi #(
    parameter int UNROLL = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    output logic          ack,
    input  logic          dec,
    input  logic [`N_K-1:0] k,
    input  logic [`N_B-1:0] m,
    output logic [`N_B-1:0] c
);
    localparam int CYC = `N_R / UNROLL;

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)
        || (`N_R % UNROLL) != 0) begin : g_bad_unroll
        $error("encrypt_multi: UNROLL must be 1, 2, 4, 8 or 16 and divide N_R");
    end

    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3;

    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                  19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                  41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    // Tables use DES bit numbering: bit 1 is the MSB of the source vector.
    function automatic logic [63:0] perm64(input logic [63:0] x, input logic fin);
        logic [63:0] r;
        for (int i = 0; i < 64; i++)
            r[6'(63-i)] = x[6'(64 - (fin ? FP_T[i] : IP_T[i]))];
        return r;
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] x);
        logic [55:0] r;
        for (int i = 0; i < 56; i++) r[6'(55-i)] = x[6'(64-PC1_T[i])];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] x);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[6'(47-i)] = x[6'(56-PC2_T[i])];
        return r;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] rr, input logic [47:0] sk);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] p;
        logic [5:0]  b;
        for (int i = 0; i < 48; i++) x[6'(47-i)] = rr[5'(32-E_T[i])];
        x = x ^ sk;
        for (int i = 0; i < 8; i++) begin
            b = x[6'(42-6*i) +: 6];
            s[5'(28-4*i) +: 4] = 4'(SBOX[i][{b[5], b[0], b[4:1]}]);
        end
        for (int i = 0; i < 32; i++) p[5'(31-i)] = s[5'(32-P_T[i])];
        return p;
    endfunction

    function automatic logic two_shift(input int r);
        return !(r == 1 || r == 2 || r == 9 || r == 16);
    endfunction

    function automatic logic [55:0] rotl(input logic [55:0] x, input logic two);
        return two ? {x[53:28], x[55:54], x[25:0], x[27:26]}
                   : {x[54:28], x[55], x[26:0], x[27]};
    endfunction

    function automatic logic [55:0] rotr(input logic [55:0] x, input logic two);
        return two ? {x[29:28], x[55:30], x[1:0], x[27:2]}
                   : {x[28], x[55:29], x[0], x[27:1]};
    endfunction

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [63:0] kq, mq;
    logic        decq;
    logic [31:0] l_q, r_q, l_n, r_n;
    logic [55:0] cd_q, cd_n;

    // Decrypt walks the schedule backwards: the first round key is the unrotated PC1 output.
    always_comb begin
        int          idx;
        logic [31:0] tmp;
        l_n  = l_q;
        r_n  = r_q;
        cd_n = cd_q;
        for (int j = 0; j < UNROLL; j++) begin
            idx = int'(cnt) * UNROLL + j;
            if (!decq)          cd_n = rotl(cd_n, two_shift(idx + 1));
            else if (idx != 0)  cd_n = rotr(cd_n, two_shift(17 - idx));
            tmp = r_n;
            r_n = l_n ^ feistel(r_n, pc2(cd_n));
            l_n = tmp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ack   <= 1'b0;
            c     <= '0;
            cnt   <= '0;
            kq    <= '0;
            mq    <= '0;
            decq  <= 1'b0;
            l_q   <= '0;
            r_q   <= '0;
            cd_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= 1'b0;
                    if (req) begin
                        kq    <= k;
                        mq    <= m;
                        decq  <= dec;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    {l_q, r_q} <= perm64(mq, 1'b0);
                    cd_q       <= pc1(kq);
                    cnt        <= '0;
                    state      <= RUN;
                end
                RUN: begin
                    l_q  <= l_n;
                    r_q  <= r_n;
                    cd_q <= cd_n;
                    cnt  <= cnt + 4'd1;
                    if (cnt == 4'(CYC - 1)) state <= DONE;
                end
                default: begin
                    if (!ack) begin
                        c   <= perm64({r_q, l_q}, 1'b1);
                        ack <= 1'b1;
                    end else if (!req) begin
                        ack   <= 1'b0;
                        state <= IDLE;
`ifdef ENCRYPT_MULTI_ZEROISE_EN
                        c    <= '0;
                        kq   <= '0;
                        mq   <= '0;
                        decq <= 1'b0;
                        l_q  <= '0;
                        r_q  <= '0;
                        cd_q <= '0;
`endif
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_encrypt_multi.sv
// Directed vector bench for encrypt_multi at UNROLL = 1, 4 and 16.
module tb_encrypt_multi;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_s [3];
    logic        ack_s [3];
    logic        dec_s [3];
    logic [63:0] k_s   [3];
    logic [63:0] m_s   [3];
    logic [63:0] c_s   [3];
    int checks = 0;
    int errors = 0;

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] C1 = 64'h85E813540F0AB405;
    localparam logic [63:0] CZ = 64'h8CA64DE9C1B123A7;

    always #5 clk = ~clk;

    encrypt_multi #(.UNROLL(1))  u1  (.clk(clk), .rst(rst), .req(req_s[0]), .ack(ack_s[0]),
                                      .dec(dec_s[0]), .k(k_s[0]), .m(m_s[0]), .c(c_s[0]));
    encrypt_multi #(.UNROLL(4))  u4  (.clk(clk), .rst(rst), .req(req_s[1]), .ack(ack_s[1]),
                                      .dec(dec_s[1]), .k(k_s[1]), .m(m_s[1]), .c(c_s[1]));
    encrypt_multi #(.UNROLL(16)) u16 (.clk(clk), .rst(rst), .req(req_s[2]), .ack(ack_s[2]),
                                      .dec(dec_s[2]), .k(k_s[2]), .m(m_s[2]), .c(c_s[2]));

    typedef struct {
        int          u;
        logic        d;
        logic [63:0] k;
        logic [63:0] m;
        logic [63:0] c;
        int          lat;
    } vec_t;

    vec_t tv [7];

    function automatic logic [63:0] after_fall(input logic [63:0] res);
`ifdef ENCRYPT_MULTI_ZEROISE_EN
        return 64'd0;
`else
        return res;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic start(input int u, input logic d, input logic [63:0] kk, input logic [63:0] mm);
        @(negedge clk);
        dec_s[u] = d;
        k_s[u]   = kk;
        m_s[u]   = mm;
        req_s[u] = 1'b1;
        @(posedge clk);
    endtask

    // Returns the number of edges until ack is seen high, or -1 on timeout.
    task automatic wait_ack(input int u, output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (ack_s[u] === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic drop_req(input int u, input string name);
        @(negedge clk);
        req_s[u] = 1'b0;
        @(posedge clk);
        #1;
        chk({name, " ack_fall"}, 64'(ack_s[u]), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int n;
        start(v.u, v.d, v.k, v.m);
        wait_ack(v.u, n);
        chk({name, " latency"}, 64'(n), 64'(v.lat));
        chk({name, " c"}, c_s[v.u], v.c);
        drop_req(v.u, name);
        chk({name, " c_after"}, c_s[v.u], after_fall(v.c));
    endtask

    initial begin
        int n;
        int highs;
        tv[0] = '{0, 1'b0, K1,    P1, C1,    18};
        tv[1] = '{1, 1'b1, K1,    C1, P1,    6};
        tv[2] = '{2, 1'b0, 64'd0, 64'd0, CZ, 3};
        tv[3] = '{2, 1'b1, K1,    C1, P1,    3};
        tv[4] = '{1, 1'b0, K1,    P1, C1,    6};
        tv[5] = '{0, 1'b1, K1,    C1, P1,    18};
        tv[6] = '{1, 1'b1, 64'd0, CZ, 64'd0, 6};
        for (int u = 0; u < 3; u++) begin
            req_s[u] = 1'b0;
            dec_s[u] = 1'b0;
            k_s[u]   = '0;
            m_s[u]   = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            chk("reset ack", 64'(ack_s[u]), 64'd0);
            chk("reset c", c_s[u], 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(tv[i], $sformatf("vec%0d", i));

        // Hold: ack and c stay put while req stays high.
        start(2, 1'b0, 64'd0, 64'd0);
        wait_ack(2, n);
        chk("hold latency", 64'(n), 64'd3);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("hold ack", 64'(ack_s[2]), 64'd1);
            chk("hold c", c_s[2], CZ);
        end
        drop_req(2, "hold");
        chk("hold c_after", c_s[2], after_fall(CZ));

        // Reset at RUN cycle 5 aborts the operation with no ack.
        start(0, 1'b0, K1, P1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst      = 1'b1;
        req_s[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst ack", 64'(ack_s[0]), 64'd0);
        chk("midrst c", c_s[0], 64'd0);
        @(negedge clk);
        rst   = 1'b0;
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (ack_s[0] === 1'b1) highs++;
        end
        chk("midrst no_ack", 64'(highs), 64'd0);
        run_vec(tv[0], "after_rst");

        // req dropped during the operation: one-cycle ack pulse.
        start(1, 1'b0, K1, P1);
        @(negedge clk);
        req_s[1] = 1'b0;
        wait_ack(1, n);
        chk("pulse latency", 64'(n), 64'd6);
        chk("pulse c", c_s[1], C1);
        @(posedge clk);
        #1;
        chk("pulse ack_fall", 64'(ack_s[1]), 64'd0);

        // Inputs changed in RUN do not disturb the captured operation.
        start(0, 1'b0, K1, P1);
        @(negedge clk);
        @(negedge clk);
        k_s[0]   = 64'hFFFF_0000_FFFF_0000;
        m_s[0]   = 64'hDEAD_BEEF_0BAD_F00D;
        dec_s[0] = 1'b1;
        wait_ack(0, n);
        chk("chg latency", 64'(n), 64'd17);
        chk("chg c", c_s[0], C1);
        drop_req(0, "chg");

        // Back-to-back: inputs present on the ack-fall edge must not be captured.
        start(2, 1'b0, K1, P1);
        wait_ack(2, n);
        chk("b2b first c", c_s[2], C1);
        drop_req(2, "b2b");
        @(negedge clk);
        k_s[2]   = 64'd0;
        m_s[2]   = 64'd0;
        req_s[2] = 1'b1;
        @(posedge clk);
        wait_ack(2, n);
        chk("b2b second latency", 64'(n), 64'd3);
        chk("b2b second c", c_s[2], CZ);
        drop_req(2, "b2b second");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
